rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter_pkg.sv | 17 +
 rtl/rr_pri_enc.sv | 27 ++
 rtl/rr_grant_arbiter.sv | 105 ++++++++++
 tb/tb_rr_grant_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared constants, FSM state type and decode helper for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8      = '0;
        onehot8[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pri_enc.sv
// Rotating priority encoder: finds the first set request at or after start_i, wrapping mod 8.
module rr_pri_enc
    import rr_grant_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        // Rotate so that bit 0 corresponds to index start_i.
        rot     = N_REQ'({req_i, req_i} >> start_i);
        found_o = |rot;
        off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        idx_o = start_i + off;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters: grants are held until released or the watchdog fires.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam bit               WdogEn   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             wdog_hit;

    rr_pri_enc u_pri_enc (
        .req_i   (req),
        .start_i (last_q + IDX_W'(1)),
        .found_o (win_found),
        .idx_o   (win_idx)
    );

    assign wdog_hit = WdogEn && (cnt_q == HoldLast);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d   = onehot8(win_idx);
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Watchdog takes precedence so a same-edge drop still reports timeout.
                if (!req[idx_q] || wdog_hit) begin
                    gnt_d     = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    timeout_d = wdog_hit;
                    last_d    = idx_q;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= IDX_W'(N_REQ - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scenario bench for rr_grant_arbiter with a small expected-output queue (MAX_HOLD = 4).
module tb_rr_grant_arbiter;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    rr_grant_arbiter #(
        .N        (8),
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic exp_t g(input int k);
        exp_t e;
        e.gnt   = 8'h01 << k;
        e.idx   = 3'(k);
        e.valid = 1'b1;
        e.to    = 1'b0;
        return e;
    endfunction

    function automatic exp_t idle(input logic to);
        exp_t e;
        e.gnt   = 8'h00;
        e.idx   = 3'd0;
        e.valid = 1'b0;
        e.to    = to;
        return e;
    endfunction

    task automatic test_reset();
        exp_t o;
        rst_n = 1'b0;
        req   = 8'hff;
        repeat (2) @(posedge clk);
        #1;
        o = {gnt, gnt_idx, gnt_valid, timeout};
        total++;
        if (o !== idle(1'b0)) begin
            bad++;
            $display("FAIL reset: got gnt=%h idx=%0d v=%b to=%b want all zero",
                     o.gnt, o.idx, o.valid, o.to);
        end
        req = 8'h00;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] rq[3];
        exp_t       ex[3];
        exp_t       e, o;
        rq = '{8'h01, 8'h00, 8'h00};
        ex = '{g(0), idle(1'b0), idle(1'b0)};
        for (int s = 0; s < 3; s++) begin
            req = rq[s];
            sb_q.push_back(ex[s]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {gnt, gnt_idx, gnt_valid, timeout};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single[%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                         s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e, o;
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 9; n++) begin
            int k = n % 8;
            for (int s = 0; s < 3; s++) begin
                req = (s == 2) ? (8'hff & ~(8'h01 << k)) : 8'hff;
                sb_q.push_back((s == 2) ? idle(1'b0) : g(k));
                @(posedge clk); #1;
                e = sb_q.pop_front();
                o = {gnt, gnt_idx, gnt_valid, timeout};
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL round_robin[%0d.%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                             n, s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
                end
            end
        end
        req = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_last_idx();
        logic [7:0] rq[7];
        exp_t       ex[7];
        exp_t       e, o;
        rq = '{8'h20, 8'h00, 8'h21, 8'h21, 8'h20, 8'h20, 8'h00};
        ex = '{g(5), idle(1'b0), g(0), g(0), idle(1'b0), g(5), idle(1'b0)};
        for (int s = 0; s < 7; s++) begin
            req = rq[s];
            sb_q.push_back(ex[s]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {gnt, gnt_idx, gnt_valid, timeout};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL last_idx[%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                         s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [7:0] rq[11];
        exp_t       ex[11];
        exp_t       e, o;
        // Second hold drops req on the same edge the watchdog fires.
        rq = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
        ex = '{g(3), g(3), g(3), g(3), idle(1'b1), g(3), g(3), g(3), g(3), idle(1'b1),
               idle(1'b0)};
        for (int s = 0; s < 11; s++) begin
            req = rq[s];
            sb_q.push_back(ex[s]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {gnt, gnt_idx, gnt_valid, timeout};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL watchdog[%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                         s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
            end
        end
    endtask

    task automatic test_ignore_others();
        logic [7:0] rq[6];
        exp_t       ex[6];
        exp_t       e, o;
        rq = '{8'h04, 8'h46, 8'h06, 8'h42, 8'h42, 8'h00};
        ex = '{g(2), g(2), g(2), idle(1'b0), g(6), idle(1'b0)};
        for (int s = 0; s < 6; s++) begin
            req = rq[s];
            sb_q.push_back(ex[s]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {gnt, gnt_idx, gnt_valid, timeout};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL ignore_others[%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                         s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] rq[5];
        exp_t       ex[5];
        exp_t       e, o;
        // Leave last_idx at 4 first, so a post-reset grant of 4 (not 5) shows the search restarted.
        rq = '{8'h10, 8'h00, 8'h10, 8'h30, 8'h00};
        ex = '{g(4), idle(1'b0), g(4), g(4), idle(1'b0)};
        for (int s = 0; s < 5; s++) begin
            if (s == 3) begin
                #3 rst_n = 1'b0;
                #1;
                o = {gnt, gnt_idx, gnt_valid, timeout};
                total++;
                if (o !== idle(1'b0)) begin
                    bad++;
                    $display("FAIL reset_mid_busy async: got gnt=%h idx=%0d v=%b to=%b want all zero",
                             o.gnt, o.idx, o.valid, o.to);
                end
                @(negedge clk) rst_n = 1'b1;
            end
            req = rq[s];
            sb_q.push_back(ex[s]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {gnt, gnt_idx, gnt_valid, timeout};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_busy[%0d]: got gnt=%h idx=%0d v=%b to=%b want gnt=%h idx=%0d v=%b to=%b",
                         s, o.gnt, o.idx, o.valid, o.to, e.gnt, e.idx, e.valid, e.to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_last_idx();
        test_watchdog();
        test_ignore_others();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got still running want finished");
        $fatal(1, "time limit");
    end

endmodule
